pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Parametrised program-counter controller that supersedes the fixed 32-bit PC register in the fetch stage. It holds the current fetch address and selects the next one from these sources: sequential increment, branch/jump redirect, exception vector, or exception return. Redirects that arrive during a stall are buffered, so a branch resolved while fetch is frozen is not lost. The block feeds instruction memory and the IF/ID pipeline register.

## Interface
- `WIDTH`, 32: address width in bits.
- `START_ADDRESS`, 32'h0000_3000: reset and initial PC.
- `EXC_VECTOR`, 32'h0000_4180: exception handler entry address.
- `STEP`, 4: sequential increment in bytes; must be a power of two.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: 1 lets the PC advance (`PC_ENABLED`); 0 means stall.
- `redirect_valid` input 1: branch/jump taken this cycle.
- `redirect_target` input WIDTH: branch/jump destination.
- `exc_req` input 1: exception raised by a downstream stage.
- `exc_pc` input WIDTH: address of the faulting instruction.
- `eret_req` input 1: return from exception.
- `curr_pc` output WIDTH: current fetch address (registered).
- `seq_pc` output WIDTH: `curr_pc + STEP`, combinational, wraps mod 2^WIDTH.
- `epc` output WIDTH: saved exception return address.
- `exl` output 1: 1 while inside the exception handler.
- `redirect_pending` output 1: a buffered redirect is waiting.
- `misalign_fault` output 1: one-cycle pulse; present only with the macro, otherwise tied 0.

## Operation
- State machine with three states:
  - RUN: no pending redirect.
  - PEND: buffered redirect waiting for `enable`.
  - EXC: `exl`=1.
  - PEND and EXC are orthogonal. `redirect_pending` and `exl` are independent flops.
- Next-PC priority, evaluated every cycle, highest first:
  1. `rst`: `curr_pc`=START_ADDRESS, `epc`=0, `exl`=0, pending cleared, `misalign_fault`=0.
  2. `exc_req` (ignores `enable`): `curr_pc`=EXC_VECTOR and pending cleared. If `exl`=0, then `epc`=`exc_pc` and `exl`=1. If `exl`=1 (nested), `epc` is unchanged.
  3. `eret_req` (ignores `enable`): `curr_pc`=`epc`, `exl`=0, pending cleared. When `exl`=0, `eret_req` still loads `epc`.
  4. `redirect_valid` with `enable`=1: `curr_pc`=`redirect_target`, and any pending redirect is discarded (the newer one wins).
  5. `redirect_valid` with `enable`=0: target captured into the pending buffer (overwrites an older pending target); `curr_pc` holds.
  6. Pending with `enable`=1: `curr_pc`=pending target, pending cleared.
  7. `enable`=1: `curr_pc`=`seq_pc`.
  8. Otherwise hold.
- `exc_req` and `eret_req` in the same cycle: `exc_req` wins.
- Arithmetic is unsigned, WIDTH bits. Incrementing from the top address wraps to 0 with no flag.

## Timing
- All state updates on the rising edge of `clk`. `curr_pc`, `epc`, `exl`, `redirect_pending` and `misalign_fault` are registered.
- A redirect, exception or eret presented in cycle N is visible on `curr_pc` in cycle N+1.
- A redirect buffered in stall cycle N appears on `curr_pc` one cycle after the first cycle with `enable`=1.
- Reset asserted mid-stall with a pending redirect discards the pending target.
- Reset values: `curr_pc`=START_ADDRESS, `seq_pc`=START_ADDRESS+STEP, `epc`=0, `exl`=0, `redirect_pending`=0, `misalign_fault`=0.

## Configuration
- Macro `PC_ALIGN_CHECK_EN`.
- Defined:
  - Any candidate next PC from a redirect, pending target or eret with a nonzero value mod STEP is replaced by EXC_VECTOR.
  - It is then handled as an exception: `epc`=the offending target if `exl`=0.
  - `exl`=1 and `misalign_fault` pulses for one cycle, aligned with the new `curr_pc`.
- Undefined: targets are loaded unchanged, and `misalign_fault` is constant 0.

## Structure
- Shared header `pc.h` holds:
  - `PC_START_ADDRESS`, `PC_EXC_VECTOR`, `PC_STEP`;
  - `PC_ENABLED`/`PC_DISABLED`;
  - state encodings.
- These supply the parameter defaults.
- One sub-module, `pc_redirect_buf`: a single-entry buffer with a valid bit and a target register, plus capture/consume/flush controls.
- Debug trace of `enable` and `curr_pc` goes through the existing debug header macros.

## Test plan
- Reset, then `enable`=1 for 3 cycles: `curr_pc` steps 0x3000 → 0x3004 → 0x3008 → 0x300C; `epc`=0, `exl`=0.
- `enable`=0 and `redirect_valid` with 0x3400 at PC 0x3008; hold 2 cycles, then `enable`=1: `curr_pc` stays 0x3008 with `redirect_pending`=1, then becomes 0x3400 with pending cleared.
- Pending 0x3400 buffered, then `redirect_valid` with 0x3800 on the cycle `enable` returns: `curr_pc`=0x3800 and pending cleared.
- `exc_req` with `exc_pc`=0x3010 during a stall, second `exc_req` with 0x4190, then `eret_req`:
  - first exception: `curr_pc`=0x4180, `epc`=0x3010, `exl`=1;
  - nested exception: `epc` stays 0x3010;
  - eret: `curr_pc`=0x3010, `exl`=0.
- With `PC_ALIGN_CHECK_EN` defined, redirect to 0x3402: `curr_pc`=0x4180, `epc`=0x3402, `misalign_fault`=1 for 1 cycle.
- Without the macro, the same redirect loads 0x3402 and `misalign_fault` stays 0.
- Reset while pending, and wrap: `rst` asserted with pending: `curr_pc`=0x3000 and pending=0. With WIDTH=8 and `curr_pc`=0xFC, an increment gives 0x00.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared program-counter constants: default addresses, step, enable levels, status encodings.
package pc_pkg;

  localparam logic [31:0] PC_START_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VECTOR    = 32'h0000_4180;
  localparam int unsigned PC_STEP          = 4;

  localparam logic PC_ENABLED  = 1'b1;
  localparam logic PC_DISABLED = 1'b0;

  // RUN/PEND/EXC are reported through independent flops (redirect_pending, exl).
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_EXC  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry holding buffer for a redirect target that arrives while fetch is stalled.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_i,
  input  logic             consume_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] target_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] target_o
);

  logic             valid_q;
  logic [WIDTH-1:0] target_q;

  // A capture overwrites any older entry; it never coincides with consume/flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else if (capture_i) begin
      valid_q  <= 1'b1;
      target_q <= target_i;
    end else if (consume_i || flush_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch program-counter controller: sequential, redirect, exception and eret sources.
// Optional PC_ALIGN_CHECK_EN turns misaligned targets into exceptions with a fault pulse.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH         = 32,
  parameter logic [WIDTH-1:0] START_ADDRESS = WIDTH'(PC_START_ADDRESS),
  parameter logic [WIDTH-1:0] EXC_VECTOR    = WIDTH'(PC_EXC_VECTOR),
  parameter int unsigned      STEP          = PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret_req,
  output logic [WIDTH-1:0] curr_pc,
  output logic [WIDTH-1:0] seq_pc,
  output logic [WIDTH-1:0] epc,
  output logic             exl,
  output logic             redirect_pending,
  output logic             misalign_fault
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             exl_q, exl_d;
  logic             fault_d;

  logic             buf_capture, buf_consume, buf_flush;
  logic             pend_vld;
  logic [WIDTH-1:0] pend_tgt;

  logic             cand_vld;
  logic [WIDTH-1:0] cand;
  logic             go;

  assign go     = (enable == PC_ENABLED);
  assign seq_pc = pc_q + WIDTH'(STEP);

  pc_redirect_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (buf_capture),
    .consume_i (buf_consume),
    .flush_i   (buf_flush),
    .target_i  (redirect_target),
    .valid_o   (pend_vld),
    .target_o  (pend_tgt)
  );

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    exl_d       = exl_q;
    fault_d     = 1'b0;
    buf_capture = 1'b0;
    buf_consume = 1'b0;
    buf_flush   = 1'b0;
    cand_vld    = 1'b0;
    cand        = pc_q;

    if (exc_req) begin
      pc_d      = EXC_VECTOR;
      buf_flush = 1'b1;
      if (!exl_q) begin
        epc_d = exc_pc;
        exl_d = 1'b1;
      end
    end else if (eret_req) begin
      cand_vld  = 1'b1;
      cand      = epc_q;
      exl_d     = 1'b0;
      buf_flush = 1'b1;
    end else if (redirect_valid && go) begin
      cand_vld  = 1'b1;
      cand      = redirect_target;
      buf_flush = 1'b1;
    end else if (redirect_valid) begin
      buf_capture = 1'b1;
    end else if (pend_vld && go) begin
      cand_vld    = 1'b1;
      cand        = pend_tgt;
      buf_consume = 1'b1;
    end else if (go) begin
      pc_d = seq_pc;
    end

    if (cand_vld) pc_d = cand;

`ifdef PC_ALIGN_CHECK_EN
    // A misaligned target is rerouted into the handler as if an exception were raised.
    if (cand_vld && ((cand & WIDTH'(STEP - 1)) != '0)) begin
      pc_d      = EXC_VECTOR;
      buf_flush = 1'b1;
      fault_d   = 1'b1;
      exl_d     = 1'b1;
      if (!exl_q) epc_d = cand;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= START_ADDRESS;
      epc_q <= '0;
      exl_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      exl_q <= exl_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign misalign_fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault   = fault_d;
  assign misalign_fault = 1'b0;
`endif

  assign curr_pc          = pc_q;
  assign epc              = epc_q;
  assign exl              = exl_q;
  assign redirect_pending = pend_vld;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus randomized traffic against a priority-rule model.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        exc_req = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        eret_req = 1'b0;
  logic [31:0] curr_pc, seq_pc, epc;
  logic        exl, redirect_pending, misalign_fault;

  // 8-bit instance for the wrap-around boundary
  logic       rst8 = 1'b0, en8 = 1'b0, z1 = 1'b0;
  logic [7:0] z8 = '0;
  logic [7:0] pc8, seq8, epc8;
  logic       exl8, pend8, fault8;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] m_pc, m_epc, m_tgt;
  logic        m_exl, m_pend, m_fault;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_req(exc_req), .exc_pc(exc_pc), .eret_req(eret_req),
    .curr_pc(curr_pc), .seq_pc(seq_pc), .epc(epc), .exl(exl),
    .redirect_pending(redirect_pending), .misalign_fault(misalign_fault)
  );

  pc_ctrl #(.WIDTH(8), .START_ADDRESS(8'hFC), .EXC_VECTOR(8'h80), .STEP(4)) dut8 (
    .clk(clk), .rst(rst8), .enable(en8),
    .redirect_valid(z1), .redirect_target(z8),
    .exc_req(z1), .exc_pc(z8), .eret_req(z1),
    .curr_pc(pc8), .seq_pc(seq8), .epc(epc8), .exl(exl8),
    .redirect_pending(pend8), .misalign_fault(fault8)
  );

  // Apply one cycle of inputs, clock it, advance the model, settle before sampling.
  task automatic tick(input logic r, input logic en, input logic rv, input logic [31:0] rt,
                      input logic ex, input logic [31:0] ep, input logic er);
    logic        load;
    logic [31:0] nxt;
    rst = r; enable = en; redirect_valid = rv; redirect_target = rt;
    exc_req = ex; exc_pc = ep; eret_req = er;
    @(posedge clk);
    load = 1'b0; nxt = '0; m_fault = 1'b0;
    if (r) begin
      m_pc = 32'h3000; m_epc = '0; m_exl = 1'b0; m_pend = 1'b0;
    end else if (ex) begin
      m_pc = 32'h4180; m_pend = 1'b0;
      if (!m_exl) begin m_epc = ep; m_exl = 1'b1; end
    end else if (er) begin
      load = 1'b1; nxt = m_epc; m_exl = 1'b0; m_pend = 1'b0;
    end else if (rv && en) begin
      load = 1'b1; nxt = rt; m_pend = 1'b0;
    end else if (rv) begin
      m_pend = 1'b1; m_tgt = rt;
    end else if (m_pend && en) begin
      load = 1'b1; nxt = m_tgt; m_pend = 1'b0;
    end else if (en) begin
      m_pc = m_pc + 32'd4;
    end
    if (load) begin
      if (ALIGN && (nxt % 4 != 0)) begin
        m_pc = 32'h4180; m_pend = 1'b0; m_fault = 1'b1;
        if (!m_exl) m_epc = nxt;
        m_exl = 1'b1;
      end else begin
        m_pc = nxt;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3000) $display("FAIL reset_pc got %h want %h", curr_pc, 32'h3000); else n_pass++;
    n_total++; if (seq_pc !== 32'h3004) $display("FAIL reset_seq got %h want %h", seq_pc, 32'h3004); else n_pass++;
    n_total++; if ({epc, exl, redirect_pending, misalign_fault} !== 35'd0)
      $display("FAIL reset_state got epc=%h exl=%b pend=%b fault=%b want all 0", epc, exl, redirect_pending, misalign_fault);
    else n_pass++;
  endtask

  task automatic test_sequential;
    logic [31:0] exp;
    for (int i = 1; i <= 3; i++) begin
      tick(0, 1, 0, 0, 0, 0, 0);
      exp = 32'h3000 + 32'(4 * i);
      n_total++; if (curr_pc !== exp) $display("FAIL seq_step%0d got %h want %h", i, curr_pc, exp); else n_pass++;
    end
    n_total++; if (epc !== 32'h0 || exl !== 1'b0) $display("FAIL seq_exc got epc=%h exl=%b want 0/0", epc, exl); else n_pass++;
  endtask

  task automatic test_stall_redirect;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 32'h3400, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3008 || redirect_pending !== 1'b1)
      $display("FAIL stall_capture got pc=%h pend=%b want 3008/1", curr_pc, redirect_pending); else n_pass++;
    tick(0, 0, 0, 0, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3008 || redirect_pending !== 1'b1)
      $display("FAIL stall_hold got pc=%h pend=%b want 3008/1", curr_pc, redirect_pending); else n_pass++;
    tick(0, 1, 0, 0, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3400 || redirect_pending !== 1'b0)
      $display("FAIL stall_release got pc=%h pend=%b want 3400/0", curr_pc, redirect_pending); else n_pass++;
  endtask

  task automatic test_newer_wins;
    tick(0, 0, 1, 32'h3400, 0, 0, 0);
    tick(0, 1, 1, 32'h3800, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3800 || redirect_pending !== 1'b0)
      $display("FAIL newer_wins got pc=%h pend=%b want 3800/0", curr_pc, redirect_pending); else n_pass++;
    tick(0, 1, 0, 0, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3804) $display("FAIL stale_discard got %h want %h", curr_pc, 32'h3804); else n_pass++;
  endtask

  task automatic test_exception_nesting;
    tick(0, 0, 0, 0, 1, 32'h3010, 0);
    n_total++; if (curr_pc !== 32'h4180 || epc !== 32'h3010 || exl !== 1'b1)
      $display("FAIL exc_first got pc=%h epc=%h exl=%b want 4180/3010/1", curr_pc, epc, exl); else n_pass++;
    tick(0, 0, 0, 0, 1, 32'h4190, 0);
    n_total++; if (curr_pc !== 32'h4180 || epc !== 32'h3010 || exl !== 1'b1)
      $display("FAIL exc_nested got pc=%h epc=%h exl=%b want 4180/3010/1", curr_pc, epc, exl); else n_pass++;
    tick(0, 0, 0, 0, 0, 0, 1);
    n_total++; if (curr_pc !== 32'h3010 || exl !== 1'b0)
      $display("FAIL eret got pc=%h exl=%b want 3010/0", curr_pc, exl); else n_pass++;
    tick(0, 0, 1, 32'h3600, 1, 32'h3020, 1);
    n_total++; if (curr_pc !== 32'h4180 || epc !== 32'h3020 || exl !== 1'b1 || redirect_pending !== 1'b0)
      $display("FAIL exc_over_eret got pc=%h epc=%h exl=%b pend=%b want 4180/3020/1/0", curr_pc, epc, exl, redirect_pending);
    else n_pass++;
  endtask

  task automatic test_misalign;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 32'h3402, 0, 0, 0);
    if (ALIGN) begin
      n_total++; if (curr_pc !== 32'h4180 || epc !== 32'h3402 || exl !== 1'b1 || misalign_fault !== 1'b1)
        $display("FAIL misalign_trap got pc=%h epc=%h exl=%b fault=%b want 4180/3402/1/1", curr_pc, epc, exl, misalign_fault);
      else n_pass++;
    end else begin
      n_total++; if (curr_pc !== 32'h3402 || misalign_fault !== 1'b0 || exl !== 1'b0)
        $display("FAIL misalign_load got pc=%h fault=%b exl=%b want 3402/0/0", curr_pc, misalign_fault, exl);
      else n_pass++;
    end
    tick(0, 0, 0, 0, 0, 0, 0);
    n_total++; if (misalign_fault !== 1'b0) $display("FAIL fault_pulse got %b want 0", misalign_fault); else n_pass++;
  endtask

  task automatic test_reset_pending;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 32'h3600, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3000 || redirect_pending !== 1'b0)
      $display("FAIL reset_pending got pc=%h pend=%b want 3000/0", curr_pc, redirect_pending); else n_pass++;
    tick(0, 1, 0, 0, 0, 0, 0);
    n_total++; if (curr_pc !== 32'h3004) $display("FAIL reset_discard got %h want %h", curr_pc, 32'h3004); else n_pass++;
  endtask

  task automatic test_wrap;
    rst8 = 1'b1; en8 = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b0;
    n_total++; if (pc8 !== 8'hFC || seq8 !== 8'h00)
      $display("FAIL wrap_reset got pc=%h seq=%h want fc/00", pc8, seq8); else n_pass++;
    en8 = 1'b1;
    @(posedge clk); #1;
    en8 = 1'b0;
    n_total++; if (pc8 !== 8'h00 || seq8 !== 8'h04 || exl8 !== 1'b0 || pend8 !== 1'b0 || fault8 !== 1'b0)
      $display("FAIL wrap_step got pc=%h seq=%h exl=%b pend=%b fault=%b want 00/04/0/0/0", pc8, seq8, exl8, pend8, fault8);
    else n_pass++;
    n_total++; if (epc8 !== 8'h00) $display("FAIL wrap_epc got %h want 00", epc8); else n_pass++;
  endtask

  task automatic test_random;
    int errs = 0;
    logic [31:0] rt, ep;
    tick(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rt = 32'h3000 + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 15) == 0) rt = rt | 32'($urandom_range(1, 3));
      ep = 32'h3000 + ($urandom_range(0, 255) << 2);
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, rt,
           $urandom_range(0, 19) == 0, ep, $urandom_range(0, 14) == 0);
      n_total++;
      if (curr_pc !== m_pc || seq_pc !== m_pc + 32'd4 || epc !== m_epc || exl !== m_exl ||
          redirect_pending !== m_pend || misalign_fault !== m_fault) begin
        if (errs < 10)
          $display("FAIL rand_cycle%0d got pc=%h seq=%h epc=%h exl=%b pend=%b fault=%b want pc=%h epc=%h exl=%b pend=%b fault=%b",
                   i, curr_pc, seq_pc, epc, exl, redirect_pending, misalign_fault, m_pc, m_epc, m_exl, m_pend, m_fault);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall_redirect;
    test_newer_wins;
    test_exception_nesting;
    test_misalign;
    test_reset_pending;
    test_wrap;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
